ofs_plat_axi_mem_lite_to_avmm_bridge: RTL and testbench

- Consumer stage downstream of the AXI-Lite channel synchronizer, where AW and W arrive together.
- Converts the AXI-Lite sink side into a pipelined Avalon-MM host command stream: one command register, in-order read data return, locally generated write responses.
- Sits in front of CSR or memory-mapped Avalon agents inside the platform shim.

---
 rtl/ofs_plat_axi_mem_lite_to_avmm_bridge.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_ofs_plat_axi_mem_lite_to_avmm_bridge.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_plat_axi_mem_lite_to_avmm_bridge.sv
// rtl/ofs_plat_axi_mem_lite_to_avmm_bridge.sv - AXI-Lite sink to pipelined Avalon-MM host bridge, optional range check via OFS_PLAT_AXI_LITE_AVMM_ADDR_CHECK_EN

module ofs_plat_axi_mem_lite_to_avmm_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(DEPTH));
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module ofs_plat_axi_mem_lite_to_avmm_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_RD     = 4,
    parameter int MAX_WR_B   = 4
`ifdef OFS_PLAT_AXI_LITE_AVMM_ADDR_CHECK_EN
    ,
    parameter longint unsigned ADDR_LIMIT = 64'd1 << ADDR_WIDTH
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    input  logic                    avmm_waitrequest,
    output logic [ADDR_WIDTH-1:0]   avmm_address,
    output logic                    avmm_read,
    output logic                    avmm_write,
    output logic [DATA_WIDTH-1:0]   avmm_writedata,
    output logic [DATA_WIDTH/8-1:0] avmm_byteenable,
    input  logic [DATA_WIDTH-1:0]   avmm_readdata,
    input  logic                    avmm_readdatavalid
);
    localparam int BE_W     = DATA_WIDTH / 8;
    localparam int RD_CNT_W = $clog2(MAX_RD + 1);
    localparam int WR_CNT_W = $clog2(MAX_WR_B + 1);

    // Command register
    logic                  cmd_valid;
    logic                  cmd_is_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [BE_W-1:0]       cmd_be;

    logic                  slot_free;
    logic                  cmd_drain;
    logic                  cmd_load;
    logic                  wr_elig;
    logic                  rd_elig;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  last_was_write;

    logic [RD_CNT_W-1:0]   rd_cnt;
    logic [WR_CNT_W-1:0]   wr_cnt;

    logic                  aw_err;
    logic                  ar_err;
    logic                  rd_err_ok;
    logic                  wr_err_ok;

    logic                  b_push;
    logic [1:0]            b_push_data;
    logic                  b_empty;
    logic                  b_full;
    logic                  b_hs;

    logic                  r_push;
    logic [DATA_WIDTH+1:0] r_push_data;
    logic [DATA_WIDTH+1:0] r_pop_data;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_hs;

`ifdef OFS_PLAT_AXI_LITE_AVMM_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] LIMIT =
        (ADDR_LIMIT >= (64'd1 << ADDR_WIDTH)) ? {1'b1, {ADDR_WIDTH{1'b0}}} : ADDR_LIMIT[ADDR_WIDTH:0];

    // Reads sitting in the command register or outstanding at the agent
    logic [RD_CNT_W-1:0] av_rd_cnt;

    assign aw_err    = ({1'b0, s_awaddr} >= LIMIT);
    assign ar_err    = ({1'b0, s_araddr} >= LIMIT);
    // Error read waits until Avalon reads have returned so R order holds
    assign rd_err_ok = (av_rd_cnt == '0);
    // Error write waits for any pending write in the register so B order holds
    // and the B FIFO never sees two pushes in one cycle
    assign wr_err_ok = !(cmd_valid && cmd_is_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            av_rd_cnt <= '0;
        end else begin
            case ({grant_rd && !ar_err, avmm_readdatavalid})
                2'b10:   av_rd_cnt <= av_rd_cnt + 1'b1;
                2'b01:   av_rd_cnt <= av_rd_cnt - 1'b1;
                default: av_rd_cnt <= av_rd_cnt;
            endcase
        end
    end
`else
    assign aw_err    = 1'b0;
    assign ar_err    = 1'b0;
    assign rd_err_ok = 1'b1;
    assign wr_err_ok = 1'b1;
`endif

    assign slot_free = !cmd_valid || !avmm_waitrequest;
    assign cmd_drain = cmd_valid && !avmm_waitrequest;

    // wr_cnt counts writes from accept to B handshake, so it bounds B FIFO occupancy
    assign wr_elig = !reset && s_awvalid && s_wvalid && slot_free &&
                     (wr_cnt < WR_CNT_W'(MAX_WR_B)) && (!aw_err || wr_err_ok);
    assign rd_elig = !reset && s_arvalid && slot_free &&
                     (rd_cnt < RD_CNT_W'(MAX_RD)) && (!ar_err || rd_err_ok);

    assign grant_wr = wr_elig && (!rd_elig || !last_was_write);
    assign grant_rd = rd_elig && !grant_wr;

    assign s_awready = grant_wr;
    assign s_wready  = grant_wr;
    assign s_arready = grant_rd;

    assign cmd_load = (grant_wr && !aw_err) || (grant_rd && !ar_err);

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid      <= 1'b0;
            cmd_is_write   <= 1'b0;
            cmd_addr       <= '0;
            cmd_data       <= '0;
            cmd_be         <= '0;
            last_was_write <= 1'b1;
        end else begin
            if (cmd_load) begin
                cmd_valid    <= 1'b1;
                cmd_is_write <= grant_wr;
                cmd_addr     <= grant_wr ? s_awaddr : s_araddr;
                cmd_data     <= s_wdata;
                cmd_be       <= grant_wr ? s_wstrb : {BE_W{1'b1}};
            end else if (cmd_drain) begin
                cmd_valid    <= 1'b0;
            end
            if (grant_wr) begin
                last_was_write <= 1'b1;
            end else if (grant_rd) begin
                last_was_write <= 1'b0;
            end
        end
    end

    assign avmm_address    = cmd_addr;
    assign avmm_read       = cmd_valid && !cmd_is_write;
    assign avmm_write      = cmd_valid && cmd_is_write;
    assign avmm_writedata  = cmd_data;
    assign avmm_byteenable = cmd_be;

    assign b_hs = s_bvalid && s_bready;
    assign r_hs = s_rvalid && s_rready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            case ({grant_rd, r_hs})
                2'b10:   rd_cnt <= rd_cnt + 1'b1;
                2'b01:   rd_cnt <= rd_cnt - 1'b1;
                default: rd_cnt <= rd_cnt;
            endcase
            case ({grant_wr, b_hs})
                2'b10:   wr_cnt <= wr_cnt + 1'b1;
                2'b01:   wr_cnt <= wr_cnt - 1'b1;
                default: wr_cnt <= wr_cnt;
            endcase
        end
    end

    assign b_push      = (cmd_drain && cmd_is_write) || (grant_wr && aw_err);
    assign b_push_data = (grant_wr && aw_err) ? 2'b10 : 2'b00;

    assign r_push      = avmm_readdatavalid || (grant_rd && ar_err);
    assign r_push_data = avmm_readdatavalid ? {2'b00, avmm_readdata} : {2'b10, {DATA_WIDTH{1'b0}}};

    ofs_plat_axi_mem_lite_to_avmm_bridge_fifo #(
        .WIDTH(2),
        .DEPTH(MAX_WR_B)
    ) b_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (b_push),
        .push_data (b_push_data),
        .pop       (s_bready),
        .pop_data  (s_bresp),
        .empty     (b_empty),
        .full      (b_full)
    );

    ofs_plat_axi_mem_lite_to_avmm_bridge_fifo #(
        .WIDTH(DATA_WIDTH + 2),
        .DEPTH(MAX_RD)
    ) r_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (r_push),
        .push_data (r_push_data),
        .pop       (s_rready),
        .pop_data  (r_pop_data),
        .empty     (r_empty),
        .full      (r_full)
    );

    // Fullness is already excluded by the wr_cnt/rd_cnt credit limits
    logic unused_full;
    assign unused_full = b_full | r_full;

    assign s_bvalid = !b_empty;
    assign s_rvalid = !r_empty;
    assign s_rresp  = r_pop_data[DATA_WIDTH+1:DATA_WIDTH];
    assign s_rdata  = r_pop_data[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_ofs_plat_axi_mem_lite_to_avmm_bridge.sv
// tb/tb_ofs_plat_axi_mem_lite_to_avmm_bridge.sv - scoreboard bench for ofs_plat_axi_mem_lite_to_avmm_bridge

module tb_ofs_plat_axi_mem_lite_to_avmm_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [15:0] s_awaddr, s_araddr, avmm_address;
    logic [63:0] s_wdata, s_rdata, avmm_writedata;
    logic [63:0] avmm_readdata = '0;
    logic [7:0]  s_wstrb, avmm_byteenable;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic        avmm_waitrequest, avmm_read, avmm_write;
    logic        avmm_readdatavalid = 1'b0;

    always #5 clk = ~clk;

    ofs_plat_axi_mem_lite_to_avmm_bridge #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(64),
        .MAX_RD(4),
        .MAX_WR_B(4)
`ifdef OFS_PLAT_AXI_LITE_AVMM_ADDR_CHECK_EN
        ,
        .ADDR_LIMIT(64'h100)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .avmm_waitrequest(avmm_waitrequest), .avmm_address(avmm_address),
        .avmm_read(avmm_read), .avmm_write(avmm_write),
        .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
        .avmm_readdata(avmm_readdata), .avmm_readdatavalid(avmm_readdatavalid)
    );

    typedef struct {
        bit          w;
        logic [15:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } cmd_t;

    int          n_total = 0;
    int          n_bad   = 0;
    cmd_t        exp_cmd[$];
    logic [1:0]  exp_b[$];
    logic [65:0] exp_r[$];
    logic [15:0] agent_q[$];
    bit          agent_hold = 1'b0;
    cmd_t        mon_e;
    logic [1:0]  mon_b;
    logic [65:0] mon_r;

    function automatic logic [63:0] rd_data_of(input logic [15:0] a);
        return {16'hBEEF, a, ~a, a ^ 16'h5A5A};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
        cmd_t c;
        c.w = 1'b1; c.addr = a; c.data = d; c.be = s;
        exp_cmd.push_back(c);
        exp_b.push_back(2'b00);
    endtask

    task automatic exp_rd(input logic [15:0] a);
        cmd_t c;
        c.w = 1'b0; c.addr = a; c.data = '0; c.be = '0;
        exp_cmd.push_back(c);
        exp_r.push_back({2'b00, rd_data_of(a)});
    endtask

    task automatic drive_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s, input string tag);
        bit acc = 1'b0;
        s_awvalid = 1'b1; s_awaddr = a; s_wvalid = 1'b1; s_wdata = d; s_wstrb = s;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            if (s_awready || s_wready) begin
                chk({tag, "_aw_w_ready_equal"}, s_awready, s_wready);
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (!acc) chk({tag, "_wr_timeout"}, 0, 1);
    endtask

    task automatic drive_read(input logic [15:0] a, input string tag);
        bit acc = 1'b0;
        s_arvalid = 1'b1; s_araddr = a;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            if (s_arready) acc = 1'b1;
            @(posedge clk); #1;
        end
        s_arvalid = 1'b0;
        if (!acc) chk({tag, "_rd_timeout"}, 0, 1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_cmd.size() == 0 && exp_b.size() == 0 && exp_r.size() == 0 && agent_q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk({tag, "_drain"}, exp_cmd.size() + exp_b.size() + exp_r.size(), 0);
    endtask

    // Monitor: every output event pops its expectation
    always @(negedge clk) begin
        if (!reset) begin
            if ((avmm_write || avmm_read) && !avmm_waitrequest) begin
                if (avmm_read) agent_q.push_back(avmm_address);
                if (exp_cmd.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                end else begin
                    mon_e = exp_cmd.pop_front();
                    chk("cmd_is_write", avmm_write, mon_e.w);
                    chk("cmd_addr", avmm_address, mon_e.addr);
                    if (mon_e.w) begin
                        chk("cmd_wdata", avmm_writedata, mon_e.data);
                        chk("cmd_be", avmm_byteenable, mon_e.be);
                    end
                end
            end
            if (s_bvalid && s_bready) begin
                if (exp_b.size() == 0) begin
                    chk("unexpected_b", 1, 0);
                end else begin
                    mon_b = exp_b.pop_front();
                    chk("b_resp", s_bresp, mon_b);
                end
            end
            if (s_rvalid && s_rready) begin
                if (exp_r.size() == 0) begin
                    chk("unexpected_r", 1, 0);
                end else begin
                    mon_r = exp_r.pop_front();
                    chk("r_data", s_rdata, mon_r[63:0]);
                    chk("r_resp", s_rresp, mon_r[65:64]);
                end
            end
        end
    end

    // Avalon agent: returns one read per cycle in issue order
    always @(posedge clk) begin
        #1;
        if (reset) begin
            agent_q.delete();
            avmm_readdatavalid = 1'b0;
        end else if (!agent_hold && agent_q.size() > 0) begin
            avmm_readdatavalid = 1'b1;
            avmm_readdata = rd_data_of(agent_q.pop_front());
        end else begin
            avmm_readdatavalid = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit got;
        reset = 1'b1;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        s_awaddr = 16'h40; s_araddr = 16'h40; s_wdata = '0; s_wstrb = '0;
        s_bready = 1'b1; s_rready = 1'b1; avmm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_readies", {s_awready, s_wready, s_arready}, 0);
        chk("reset_outputs", {s_bvalid, s_rvalid, avmm_read, avmm_write}, 0);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single write with one-cycle accept-to-command latency
        exp_wr(16'h40, 64'hA5, 8'hFF);
        drive_write(16'h40, 64'hA5, 8'hFF, "t1");
        chk("wr_latency", {avmm_write, avmm_address, avmm_byteenable}, {1'b1, 16'h0040, 8'hFF});
        chk("wr_latency_data", avmm_writedata, 64'hA5);
        wait_drain("t1");

        // AW without W is never accepted
        s_awvalid = 1'b1; s_awaddr = 16'h48; s_wdata = 64'h1122_3344_5566_7788; s_wstrb = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("aw_only_no_accept", {s_awready, s_wready, avmm_write}, 0);
        end
        @(posedge clk); #1;
        exp_wr(16'h48, 64'h1122_3344_5566_7788, 8'h0F);
        s_wvalid = 1'b1;
        @(negedge clk);
        chk("aw_w_ready_together", {s_awready, s_wready}, 2'b11);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        wait_drain("t2");

        // Read limit: 6 reads, R held off
        s_rready = 1'b0;
        for (int k = 0; k < 6; k++) exp_rd(16'(16'h20 + 8 * k));
        acc = 0;
        s_arvalid = 1'b1; s_araddr = 16'h20;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            got = s_arready;
            @(posedge clk); #1;
            if (got) begin
                acc++;
                s_araddr = 16'(16'h20 + 8 * acc);
            end
        end
        chk("rd_accept_limit", acc, 4);
        @(negedge clk);
        chk("arready_low_at_limit", s_arready, 0);
        @(posedge clk); #1;
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = s_arready;
            @(posedge clk); #1;
        end
        chk("rd_accept_after_one_r", got, 1);
        s_arvalid = 1'b0;
        s_rready = 1'b1;
        drive_read(16'(16'h20 + 8 * 5), "t3");
        wait_drain("t3");

        // Command held stable under waitrequest, next write waits for drain
        avmm_waitrequest = 1'b1;
        exp_wr(16'h60, 64'hDEAD_BEEF_0000_0001, 8'hF0);
        exp_wr(16'h68, 64'h0BAD_F00D_0000_0002, 8'h3C);
        drive_write(16'h60, 64'hDEAD_BEEF_0000_0001, 8'hF0, "t4a");
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_awaddr = 16'h68; s_wdata = 64'h0BAD_F00D_0000_0002; s_wstrb = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_hold_addr", avmm_address, 16'h60);
            chk("wait_hold_data", avmm_writedata, 64'hDEAD_BEEF_0000_0001);
            chk("wait_no_accept", {s_awready, avmm_write}, 2'b01);
            @(posedge clk); #1;
        end
        avmm_waitrequest = 1'b0;
        @(negedge clk);
        chk("accept_on_drain", s_awready, 1);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        wait_drain("t4");

        // Alternation after reset, read first
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        exp_rd(16'h80);
        exp_wr(16'h90, 64'h9000, 8'h01);
        exp_rd(16'h88);
        exp_wr(16'h98, 64'h9800, 8'h02);
        exp_rd(16'hA0);
        exp_wr(16'hA8, 64'hA800, 8'h04);
        fork
            begin
                drive_read(16'h80, "t5r0");
                drive_read(16'h88, "t5r1");
                drive_read(16'hA0, "t5r2");
            end
            begin
                drive_write(16'h90, 64'h9000, 8'h01, "t5w0");
                drive_write(16'h98, 64'h9800, 8'h02, "t5w1");
                drive_write(16'hA8, 64'hA800, 8'h04, "t5w2");
            end
        join
        wait_drain("t5");

`ifdef OFS_PLAT_AXI_LITE_AVMM_ADDR_CHECK_EN
        // Out-of-range read returns behind in-flight reads without reaching Avalon
        agent_hold = 1'b1;
        exp_rd(16'h10);
        exp_rd(16'h18);
        exp_r.push_back({2'b10, 64'h0});
        drive_read(16'h10, "t6r0");
        drive_read(16'h18, "t6r1");
        s_arvalid = 1'b1; s_araddr = 16'h200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("err_rd_waits", s_arready, 0);
            @(posedge clk); #1;
        end
        agent_hold = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = s_arready;
            @(posedge clk); #1;
        end
        s_arvalid = 1'b0;
        chk("err_rd_accepted", got, 1);
        exp_b.push_back(2'b10);
        drive_write(16'h300, 64'h77, 8'hFF, "t6w");
        wait_drain("t6");
`endif

        wait_drain("final");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
